// File: rtl/uart_sample_tx_if.sv
// Sample handshake between the audio engine and the UART serialiser.
// The engine side is the master (strobe + data); the serialiser is the slave (ready).
interface uart_sample_tx_if;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/uart_sample_tx.sv
// Generic synchronous FIFO with occupancy count; head word is presented combinationally.
// Latency: a push is visible at dout on the cycle after the pushing edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Queues 16-bit audio samples and sends each as an 8N1 frame: sync, MSB, LSB.
// Latency: sample written at edge N is popped at N+1; start bit appears on ftdi_tx from N+2.
// Backpressure: sample_ready drops when the FIFO is full; strobes seen then are counted in drop_cnt.
module uart_sample_tx #(
  parameter int          CLK_DIV    = 104,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  uart_sample_tx_if.slave    smp,
  output logic               ftdi_tx,
  output logic               busy,
  output logic [7:0]         drop_cnt
);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  shift;
  logic [15:0] hold;

  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_head;
  logic        push, pop, bit_end;

  assign bit_end          = (timer == DIV_LAST);
  assign smp.sample_ready = !fifo_full && !rst;
  assign push             = smp.sample_valid && smp.sample_ready;
  // The pop must coincide with the edge that loads hold, so it mirrors the FSM's load conditions.
  assign pop = !rst && !fifo_empty &&
               ((state == IDLE) || (state == STOP && bit_end && byte_idx == 2'd2));

  fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (smp.sample_in),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      hold     <= '0;
      ftdi_tx  <= 1'b1;
      busy     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      // Line level follows the state one cycle later, so each bit lasts exactly CLK_DIV cycles.
      ftdi_tx <= (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
      busy    <= !fifo_empty || (state != IDLE);
      if (smp.sample_valid && !smp.sample_ready && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      case (state)
        IDLE: begin
          timer <= '0;
          if (!fifo_empty) begin
            hold     <= fifo_head;
            byte_idx <= 2'd0;
            shift    <= SYNC_BYTE;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (byte_idx < 2'd2) begin
              byte_idx <= byte_idx + 2'd1;
              shift    <= (byte_idx == 2'd0) ? hold[15:8] : hold[7:0];
              state    <= START;
            end else if (!fifo_empty) begin
              hold     <= fifo_head;
              byte_idx <= 2'd0;
              shift    <= SYNC_BYTE;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_sample_tx.md
# uart_sample_tx

Serialises audio samples produced by `audioEngine` onto the FTDI UART line. It accepts one 16-bit sample per strobe into a 4-deep FIFO. Each sample goes out as a 3-byte frame (sync, MSB, LSB) in 8N1 format on `ftdi_tx`. It sits between the engine's sample output and the board's `ftdi_tx` pin, which lets the host capture the audio stream.

## Interface
- `CLK_DIV`, 104: clock cycles per UART bit; legal range is 2 to 65535.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.
- `FIFO_DEPTH`, 4: sample FIFO depth; must be a power of two, at least 2.
- `clk` in 1: single system clock; all logic is on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `sample_in` in 16: sample word, two's complement, passed through untouched.
- `sample_valid` in 1: single-cycle strobe; each high cycle is one sample.
- `sample_ready` out 1: FIFO not full; forced to 0 while `rst` is high.
- `ftdi_tx` out 1: UART serial output; registered; idles high.
- `busy` out 1: high when the FIFO is non-empty or the serialiser is not IDLE.
- `drop_cnt` out 8: count of samples lost to a full FIFO; saturates at 255.

## Operation
- Write: on an edge with `sample_valid && sample_ready`, `sample_in` is pushed into the FIFO.
- Drop: on an edge with `sample_valid && !sample_ready`, the sample is discarded and `drop_cnt` increments by 1, saturating at 255.
- FIFO behaviour:
  - Synchronous, with read and write pointers plus an occupancy count of width log2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push and a pop on the same edge leave the count unchanged.
  - When full, a pop and a push on the same edge cannot occur, because `sample_ready` is already 0.
- Serialiser states:
  - IDLE: `ftdi_tx`=1. If the FIFO is non-empty, pop the head into a 16-bit holding register, set byte_idx=0, load the shift register with SYNC_BYTE, and go to START.
  - START: `ftdi_tx`=0 for CLK_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: `ftdi_tx`=shift[0] for CLK_DIV cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: `ftdi_tx`=1 for CLK_DIV cycles. Then:
    - if byte_idx<2: increment byte_idx, load the shift register with hold[15:8] (byte 1) or hold[7:0] (byte 2), and go to START;
    - otherwise, if the FIFO is non-empty, pop, load SYNC_BYTE, and go straight to START with no idle gap;
    - otherwise go to IDLE.
- Bit order: LSB first within each byte. Byte order: SYNC_BYTE, sample[15:8], sample[7:0].
- Bit timer: counts 0 to CLK_DIV-1 and wraps at the end of every bit period. Its width is 16 bits.
- Reset, including mid-frame:
  - FIFO is emptied, the state goes to IDLE, and all counters clear.
  - `ftdi_tx`=1 and `drop_cnt`=0 from the first edge with `rst` high.
  - `busy`=0, and `sample_ready`=0 while `rst` is high.
  - Strobes arriving while `rst` is high are ignored and not counted.
  - The partial frame is abandoned; it is not resumed.

## Timing
- Reset values: `ftdi_tx`=1, `busy`=0, `drop_cnt`=0.
- `sample_ready`=0 during reset and 1 on the first cycle after `rst` falls.
- Latency:
  - A sample written at edge N into an empty FIFO with the serialiser IDLE is popped at edge N+1.
  - `ftdi_tx` goes low, starting the start bit of SYNC_BYTE, from edge N+2.
- Frame length: exactly 30×CLK_DIV cycles. Back-to-back frames are contiguous.
- `busy`:
  - rises on the edge after the first write;
  - falls on the edge where the last STOP completes with the FIFO empty.
- `sample_ready` is combinational from the FIFO count.
  - It falls in the cycle after the write that fills the FIFO.
  - It rises in the cycle after a pop from a full FIFO.
- Sustained throughput is 1 sample per 30×CLK_DIV cycles. The source must average below this rate or samples are dropped.

## Test plan
- Single sample, with CLK_DIV=4 and `sample_in`=16'h1234 strobed once after reset:
  - `ftdi_tx` low 2 cycles after the strobe;
  - decoded bytes are A5, 12, 34 (LSB first), each bit lasting 4 cycles;
  - total frame is 120 cycles, after which `busy` falls and `ftdi_tx`=1.
- Back-to-back frames, with CLK_DIV=4 and strobes of 16'h0001 then 16'hFFFF one cycle apart:
  - bytes A5 00 01 A5 FF FF with no idle cycles between the frames;
  - `busy` stays high for 240 cycles.
- Overflow, with CLK_DIV=4 and 6 strobes on consecutive cycles:
  - the first is popped and the next 4 fill the FIFO;
  - the 6th sees `sample_ready`=0, so `drop_cnt`=1;
  - exactly 5 frames are transmitted.
- Saturation: hold `sample_valid` high for 400 cycles with CLK_DIV=100 → `drop_cnt` stops at 255 and does not wrap.
- Reset mid-frame: assert `rst` for 1 cycle during DATA of byte 1 →
  - `ftdi_tx`=1 and `busy`=0 from that edge;
  - queued samples are discarded;
  - a new strobe afterwards produces a clean frame starting with A5.
- CLK_DIV=2 boundary: a sample of 16'h8000 produces bit periods of exactly 2 cycles and bytes A5 80 00.
